// File: rtl/accum_writeback_pkg.sv
// Shared types and constants for the accumulator write-back stage.
// Default control-word layout: [15] last, [14] clear, [2:0] row.
package accum_writeback_pkg;

   localparam int ACCUM_CWIDTH    = 16;
   localparam int ACCUM_ROWS      = 8;
   localparam int ACCUM_ADDR_W    = $clog2(ACCUM_ROWS);
   localparam int ACCUM_LAST_BIT  = ACCUM_CWIDTH - 1;
   localparam int ACCUM_CLEAR_BIT = ACCUM_CWIDTH - 2;

   typedef struct packed {
      logic                                   last;
      logic                                   clear;
      logic [ACCUM_CWIDTH-3-ACCUM_ADDR_W:0]   rsvd;
      logic [ACCUM_ADDR_W-1:0]                row;
   } accum_ctrl_t;

   typedef enum logic {
      ACC   = 1'b0,
      DRAIN = 1'b1
   } wb_state_e;

endpackage

// File: rtl/accum_writeback_lane_add.sv
// One lane of the accumulator adder: sign-extends the partial sum and adds it
// to the (optionally cleared) old value. Saturates when ACCUM_SATURATE_EN is defined.
module accum_lane_add #(
   parameter int PWIDTH = 16,
   parameter int AWIDTH = 32
) (
   input  logic [AWIDTH-1:0] old,
   input  logic [PWIDTH-1:0] psum,
   input  logic              clear,
   output logic [AWIDTH-1:0] sum
);

   logic [AWIDTH-1:0] base;
   logic [AWIDTH-1:0] ext;
   logic [AWIDTH-1:0] raw;

   assign base = clear ? '0 : old;
   assign ext  = {{(AWIDTH-PWIDTH){psum[PWIDTH-1]}}, psum};
   assign raw  = base + ext;

`ifdef ACCUM_SATURATE_EN
   localparam logic [AWIDTH-1:0] SAT_MAX = {1'b0, {(AWIDTH-1){1'b1}}};
   localparam logic [AWIDTH-1:0] SAT_MIN = {1'b1, {(AWIDTH-1){1'b0}}};

   // Overflow only when both operands share a sign and the result flips it.
   logic ovf;
   assign ovf = (base[AWIDTH-1] == ext[AWIDTH-1]) && (raw[AWIDTH-1] != base[AWIDTH-1]);
   assign sum = ovf ? (base[AWIDTH-1] ? SAT_MIN : SAT_MAX) : raw;
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/accum_writeback.sv
// GEMM accumulator write-back: pairs control words with psum rows, RMWs a register bank,
// and streams finished rows out. Optional saturation via `define ACCUM_SATURATE_EN.
module accum_writeback
   import accum_writeback_pkg::*;
#(
   parameter int COLS   = 4,
   parameter int PWIDTH = 16,
   parameter int AWIDTH = 32,
   parameter int ROWS   = 8,
   parameter int CWIDTH = 16,
   parameter int ADDR_W = $clog2(ROWS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CWIDTH-1:0]        fifo_dout,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic                     psum_valid,
   input  logic [COLS*PWIDTH-1:0]   psum_data,
   output logic                     psum_ready,
   output logic                     out_valid,
   output logic [COLS*AWIDTH-1:0]   out_data,
   input  logic                     out_ready,
   output logic                     err_underrun
);

   wb_state_e state_q, state_d;

   logic [ROWS-1:0][COLS-1:0][AWIDTH-1:0] bank_q;
   logic [COLS-1:0][AWIDTH-1:0]           old_row;
   logic [COLS-1:0][AWIDTH-1:0]           new_row;
   logic [COLS*AWIDTH-1:0]                out_data_q;
   logic                                  out_valid_q;
   logic                                  err_q;

   logic              ctl_last;
   logic              ctl_clear;
   logic [ADDR_W-1:0] ctl_row;
   logic              accept;
   logic              unused_ctl;

   assign ctl_last   = fifo_dout[CWIDTH-1];
   assign ctl_clear  = fifo_dout[CWIDTH-2];
   assign ctl_row    = fifo_dout[ADDR_W-1:0];
   assign unused_ctl = ^fifo_dout[CWIDTH-3:ADDR_W];

   assign accept  = psum_ready;
   assign old_row = bank_q[ctl_row];

   for (genvar i = 0; i < COLS; i++) begin : g_lane
      accum_lane_add #(
         .PWIDTH (PWIDTH),
         .AWIDTH (AWIDTH)
      ) u_add (
         .old   (old_row[i]),
         .psum  (psum_data[i*PWIDTH +: PWIDTH]),
         .clear (ctl_clear),
         .sum   (new_row[i])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ACC;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC:     if (accept && ctl_last)     state_d = DRAIN;
         DRAIN:   if (out_valid_q && out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // Handshake outputs; held low during reset so nothing is popped in the reset cycle.
   always_comb begin
      psum_ready = 1'b0;
      fifo_rd_en = 1'b0;
      if (rst && state_q == ACC) begin
         psum_ready = psum_valid && !fifo_empty;
         fifo_rd_en = psum_valid && !fifo_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bank_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         if (accept) bank_q[ctl_row] <= new_row;

         if (accept && ctl_last) begin
            out_data_q  <= new_row;
            out_valid_q <= 1'b1;
         end else if (state_q == DRAIN && out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (state_q == ACC && psum_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign err_underrun = err_q;

endmodule

// File: tb/tb_accum_writeback.sv
// Directed self-checking bench for accum_writeback (default parameters).
module tb_accum_writeback;
   import accum_writeback_pkg::*;

   localparam int COLS   = 4;
   localparam int PWIDTH = 16;
   localparam int AWIDTH = 32;

   logic                   clk;
   logic                   rst;
   logic [15:0]            fifo_dout;
   logic                   fifo_empty;
   logic                   fifo_rd_en;
   logic                   psum_valid;
   logic [COLS*PWIDTH-1:0] psum_data;
   logic                   psum_ready;
   logic                   out_valid;
   logic [COLS*AWIDTH-1:0] out_data;
   logic                   out_ready;
   logic                   err_underrun;

   int n_checks = 0;
   int n_fail   = 0;
   int pops     = 0;

   accum_writeback dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_dout    (fifo_dout),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .psum_valid   (psum_valid),
      .psum_data    (psum_data),
      .psum_ready   (psum_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .err_underrun (err_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (fifo_rd_en === 1'b1) pops++;

   function automatic logic [15:0] mk(input logic last, input logic clear, input logic [2:0] row);
      accum_ctrl_t c;
      c       = '0;
      c.last  = last;
      c.clear = clear;
      c.row   = row;
      return c;
   endfunction

   function automatic logic [COLS*AWIDTH-1:0] rowval(input logic [AWIDTH-1:0] v);
      return {COLS{v}};
   endfunction

   // Drive one word+psum at a negedge and wait (bounded) for the accepting posedge.
   task automatic send(input logic [15:0] ctrl, input logic [15:0] p, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      fifo_dout  = ctrl;
      fifo_empty = 1'b0;
      psum_valid = 1'b1;
      psum_data  = {COLS{p}};
      for (int k = 0; k < 32; k++) begin
         #1;
         if (psum_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
   endtask

   task automatic test_reset();
      bit ok;
      rst        = 1'b0;
      fifo_dout  = mk(1'b1, 1'b0, 3'd1);
      fifo_empty = 1'b0;
      psum_valid = 1'b1;
      psum_data  = '0;
      out_ready  = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (fifo_rd_en !== 1'b0 || psum_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: rd_en=%b ready=%b required 0/0", fifo_rd_en, psum_ready);
         end
      end
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || err_underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h err=%b required 0/0/0", out_valid, out_data, err_underrun);
      end
      rst        = 1'b1;
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b0 || err_underrun !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle%0d: valid=%b err=%b rd_en=%b required 0/0/0", c, out_valid, err_underrun, fifo_rd_en);
         end
      end
      // Bank starts at zero: accumulate without clear and read back the psum alone.
      send(mk(1'b1, 1'b0, 3'd5), 16'd3, ok);
      @(negedge clk); #1;
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      n_checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== rowval(32'd3)) begin
         n_fail++;
         $display("FAIL bank_zero: ok=%b valid=%b data=%h required 1/1/%h", ok, out_valid, out_data, rowval(32'd3));
      end
      idle();
   endtask

   task automatic test_accumulate();
      bit ok1, ok2, ok3;
      int p0;
      out_ready = 1'b1;
      p0 = pops;
      send(mk(1'b0, 1'b1, 3'd2), 16'd5, ok1);
      send(mk(1'b0, 1'b0, 3'd2), 16'd7, ok2);
      send(mk(1'b1, 1'b0, 3'd2), 16'hFFFD, ok3);
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (!(ok1 && ok2 && ok3) || out_valid !== 1'b1 || out_data !== rowval(32'd9)) begin
         n_fail++;
         $display("FAIL accum_result: ok=%b%b%b valid=%b data=%h required 111/1/%h", ok1, ok2, ok3, out_valid, out_data, rowval(32'd9));
      end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL accum_valid_pulse: valid=%b required 0", out_valid);
      end
      n_checks++;
      if (pops - p0 !== 3) begin
         n_fail++;
         $display("FAIL accum_pops: got %0d required 3", pops - p0);
      end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, ok3;
      int p0;
      out_ready = 1'b0;
      p0 = pops;
      send(mk(1'b0, 1'b1, 3'd2), 16'd5, ok1);
      send(mk(1'b0, 1'b0, 3'd2), 16'd7, ok2);
      send(mk(1'b1, 1'b0, 3'd2), 16'hFFFD, ok3);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            fifo_dout = mk(1'b1, 1'b1, 3'd3);
            psum_data = {COLS{16'd1}};
         end
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== rowval(32'd9) || psum_ready !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: valid=%b data=%h ready=%b rd_en=%b required 1/%h/0/0", c, out_valid, out_data, psum_ready, fifo_rd_en, rowval(32'd9));
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (psum_ready !== 1'b0 || fifo_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL handshake_cycle: ready=%b rd_en=%b required 0/0", psum_ready, fifo_rd_en);
      end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || psum_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL resume: valid=%b ready=%b required 0/1", out_valid, psum_ready);
      end
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (!(ok1 && ok2 && ok3) || out_valid !== 1'b1 || out_data !== rowval(32'd1) || pops - p0 !== 4) begin
         n_fail++;
         $display("FAIL resume_result: valid=%b data=%h pops=%0d required 1/%h/4", out_valid, out_data, pops - p0, rowval(32'd1));
      end
      idle();
   endtask

   task automatic test_underrun();
      bit ok;
      out_ready = 1'b1;
      @(negedge clk);
      psum_valid = 1'b1;
      fifo_empty = 1'b1;
      psum_data  = {COLS{16'd9}};
      #1;
      n_checks++;
      if (psum_ready !== 1'b0 || fifo_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_accept: ready=%b rd_en=%b required 0/0", psum_ready, fifo_rd_en);
      end
      @(negedge clk); #1;
      n_checks++;
      if (err_underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_flag: err=%b required 1", err_underrun);
      end
      psum_valid = 1'b0;
      send(mk(1'b1, 1'b1, 3'd4), 16'd2, ok);
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (!ok || out_data !== rowval(32'd2) || err_underrun !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_sticky: ok=%b data=%h err=%b required 1/%h/1", ok, out_data, err_underrun, rowval(32'd2));
      end
      idle();
   endtask

   task automatic test_overflow();
      bit ok;
      bit all_ok;
      logic [AWIDTH-1:0] exp_v;
`ifdef ACCUM_SATURATE_EN
      exp_v = 32'h7FFF_FFFF;
`else
      exp_v = 32'h8000_0010;
`endif
      out_ready = 1'b1;
      // 65537 * 0x7FFF + 0x7FF1 = 0x7FFFFFF0
      send(mk(1'b0, 1'b1, 3'd0), 16'h7FFF, all_ok);
      for (int k = 0; k < 65536; k++) begin
         send(mk(1'b0, 1'b0, 3'd0), 16'h7FFF, ok);
         all_ok &= ok;
      end
      send(mk(1'b0, 1'b0, 3'd0), 16'h7FF1, ok);
      all_ok &= ok;
      send(mk(1'b1, 1'b0, 3'd0), 16'h0020, ok);
      all_ok &= ok;
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (!all_ok || out_valid !== 1'b1 || out_data !== rowval(exp_v)) begin
         n_fail++;
         $display("FAIL overflow: ok=%b valid=%b data=%h required 1/1/%h", all_ok, out_valid, out_data, rowval(exp_v));
      end
      idle();
   endtask

   task automatic test_reset_drain();
      bit ok;
      int p0;
      out_ready = 1'b0;
      send(mk(1'b1, 1'b1, 3'd6), 16'd10, ok);
      @(negedge clk); #1;
      n_checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== rowval(32'd10)) begin
         n_fail++;
         $display("FAIL drain_setup: ok=%b valid=%b data=%h required 1/1/%h", ok, out_valid, out_data, rowval(32'd10));
      end
      @(negedge clk);
      fifo_dout  = mk(1'b1, 1'b0, 3'd6);
      psum_data  = {COLS{16'd4}};
      rst        = 1'b0;
      p0         = pops;
      #1;
      n_checks++;
      if (psum_ready !== 1'b0 || fifo_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_pop: ready=%b rd_en=%b required 0/0", psum_ready, fifo_rd_en);
      end
      @(negedge clk);
      psum_valid = 1'b0;
      rst        = 1'b1;
      out_ready  = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || err_underrun !== 1'b0 || pops !== p0) begin
         n_fail++;
         $display("FAIL reset_drain: valid=%b data=%h err=%b pops=%0d required 0/0/0/%0d", out_valid, out_data, err_underrun, pops, p0);
      end
      send(mk(1'b1, 1'b0, 3'd6), 16'd4, ok);
      @(negedge clk);
      psum_valid = 1'b0;
      fifo_empty = 1'b1;
      #1;
      n_checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== rowval(32'd4)) begin
         n_fail++;
         $display("FAIL post_reset_row: ok=%b valid=%b data=%h required 1/1/%h", ok, out_valid, out_data, rowval(32'd4));
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_accumulate();
      test_backpressure();
      test_underrun();
      test_overflow();
      test_reset_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
